// File: rtl/keyboard_pkg.sv
// Shared constants and types for the PS/2 keyboard path: set-2 scancodes,
// Apple-1 ASCII control codes and the receive FSM state type.
package keyboard_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_F1     = 8'h05;

  localparam logic [6:0] ASCII_CR     = 7'h0D;
  localparam logic [6:0] ASCII_ESC    = 7'h1B;
  localparam logic [6:0] ASCII_RUBOUT = 7'h5F;
  localparam logic [6:0] ASCII_SPACE  = 7'h20;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  function automatic logic is_letter(input logic [6:0] c);
    return (c >= 7'h41) && (c <= 7'h5A);
  endfunction

endpackage

// File: rtl/keyboard_if.sv
// CPU-side register port of the keyboard block plus its event pulses and a
// debug view of the receive FSM state.
interface keyboard_if;
  import keyboard_pkg::*;

  // key_ready is the valid; an address-0 read qualified by cpu_clken is the
  // ready that consumes it. A new character landing in the same cycle as that
  // read takes priority, so key_ready stays set for the newer character.
  logic       cpu_clken;
  logic       address;
  logic       r_en;
  logic [7:0] dout;
  logic       key_ready;
  logic       clr_screen;
  logic       frame_err;
  rx_state_t  rx_state;

  modport master (
    output cpu_clken, address, r_en,
    input  dout, key_ready, clr_screen, frame_err, rx_state
  );

  modport slave (
    input  cpu_clken, address, r_en,
    output dout, key_ready, clr_screen, frame_err, rx_state
  );

endinterface

// File: rtl/keyboard_ps2_rx.sv
// PS/2 frame receiver: input synchronisers, ps2_clk glitch filter, 11-bit
// frame FSM with odd parity and stop checks, and an inter-edge timeout.
module keyboard_ps2_rx
  import keyboard_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 16384
) (
  input  logic       sys_clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output rx_state_t  state
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_ok;
  logic          fall;
  logic          dat;

  // The filtered level flips on the cycle the last of FILTER_LEN differing
  // samples arrives; a 1->0 flip is the accepted falling edge.
  assign fall = clk_filt && !clk_sync[1] && (filt_cnt == FW'(FILTER_LEN - 1));
  assign dat  = dat_sync[1];

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RX_IDLE;
      code       <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      idle_cnt   <= '0;
      shreg      <= 8'h00;
      bit_cnt    <= 3'd0;
      par_ok     <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == RX_IDLE) begin
        idle_cnt <= '0;
        if (fall) begin
          if (!dat) begin
            state   <= RX_DATA;
            bit_cnt <= 3'd0;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (fall) begin
        idle_cnt <= '0;
        case (state)
          RX_DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par_ok <= ^{shreg, dat};
            state  <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            if (dat && par_ok) begin
              code       <= shreg;
              code_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
        // Stalled mid-frame: drop the partial byte without flagging an error.
        state    <= RX_IDLE;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keyboard.sv
// Keyboard top: PS/2 receive, set-2 to Apple-1 ASCII decode with shift/ctrl
// tracking, held key register and KBD/KBDCR read mux.
module keyboard
  import keyboard_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 16384
) (
  input  logic        sys_clock,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  keyboard_if.slave   bus
);

  logic [7:0] code;
  logic       code_valid;
  logic       rx_frame_err;
  rx_state_t  rx_state;

  logic       shift_f;
  logic       ctrl_f;
  logic       break_f;
  logic       ext_f;
  logic [7:0] kbd_data;
  logic       key_ready;
  logic       clr_screen;

  logic       map_hit;
  logic [6:0] map_ch;
  logic [6:0] char_out;
  logic       cpu_take;

  keyboard_ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .sys_clock  (sys_clock),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_valid (code_valid),
    .frame_err  (rx_frame_err),
    .state      (rx_state)
  );

  // Set-2 make code to ASCII; letters are always upper case.
  always_comb begin
    map_hit = 1'b1;
    map_ch  = 7'h00;
    case (code)
      8'h1C: map_ch = 7'h41;  8'h32: map_ch = 7'h42;  8'h21: map_ch = 7'h43;
      8'h23: map_ch = 7'h44;  8'h24: map_ch = 7'h45;  8'h2B: map_ch = 7'h46;
      8'h34: map_ch = 7'h47;  8'h33: map_ch = 7'h48;  8'h43: map_ch = 7'h49;
      8'h3B: map_ch = 7'h4A;  8'h42: map_ch = 7'h4B;  8'h4B: map_ch = 7'h4C;
      8'h3A: map_ch = 7'h4D;  8'h31: map_ch = 7'h4E;  8'h44: map_ch = 7'h4F;
      8'h4D: map_ch = 7'h50;  8'h15: map_ch = 7'h51;  8'h2D: map_ch = 7'h52;
      8'h1B: map_ch = 7'h53;  8'h2C: map_ch = 7'h54;  8'h3C: map_ch = 7'h55;
      8'h2A: map_ch = 7'h56;  8'h1D: map_ch = 7'h57;  8'h22: map_ch = 7'h58;
      8'h35: map_ch = 7'h59;  8'h1A: map_ch = 7'h5A;
      8'h16: map_ch = shift_f ? 7'h21 : 7'h31;
      8'h1E: map_ch = shift_f ? 7'h40 : 7'h32;
      8'h26: map_ch = shift_f ? 7'h23 : 7'h33;
      8'h25: map_ch = shift_f ? 7'h24 : 7'h34;
      8'h2E: map_ch = shift_f ? 7'h25 : 7'h35;
      8'h36: map_ch = shift_f ? 7'h5E : 7'h36;
      8'h3D: map_ch = shift_f ? 7'h26 : 7'h37;
      8'h3E: map_ch = shift_f ? 7'h2A : 7'h38;
      8'h46: map_ch = shift_f ? 7'h28 : 7'h39;
      8'h45: map_ch = shift_f ? 7'h29 : 7'h30;
      8'h4E: map_ch = shift_f ? 7'h5F : 7'h2D;
      8'h55: map_ch = shift_f ? 7'h2B : 7'h3D;
      8'h41: map_ch = shift_f ? 7'h3C : 7'h2C;
      8'h49: map_ch = shift_f ? 7'h3E : 7'h2E;
      8'h4A: map_ch = shift_f ? 7'h3F : 7'h2F;
      8'h4C: map_ch = shift_f ? 7'h3A : 7'h3B;
      8'h52: map_ch = shift_f ? 7'h22 : 7'h27;
      8'h54: map_ch = shift_f ? 7'h7B : 7'h5B;
      8'h5B: map_ch = shift_f ? 7'h7D : 7'h5D;
      8'h5D: map_ch = shift_f ? 7'h7C : 7'h5C;
      8'h0E: map_ch = shift_f ? 7'h7E : 7'h60;
      SC_ENTER: map_ch = ASCII_CR;
      8'h66:    map_ch = ASCII_RUBOUT;
      8'h76:    map_ch = ASCII_ESC;
      8'h29:    map_ch = ASCII_SPACE;
      default:  map_hit = 1'b0;
    endcase
  end

  assign char_out = (ctrl_f && is_letter(map_ch)) ? (map_ch & 7'h1F) : map_ch;
  assign cpu_take = bus.cpu_clken && bus.r_en && !bus.address;

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_f    <= 1'b0;
      ctrl_f     <= 1'b0;
      break_f    <= 1'b0;
      ext_f      <= 1'b0;
      kbd_data   <= 8'h00;
      key_ready  <= 1'b0;
      clr_screen <= 1'b0;
    end else begin
      clr_screen <= 1'b0;
      if (cpu_take) key_ready <= 1'b0;
      if (code_valid) begin
        if (code == SC_BREAK) begin
          break_f <= 1'b1;
        end else if (code == SC_EXT) begin
          ext_f <= 1'b1;
        end else if (break_f) begin
          if (code == SC_LSHIFT || code == SC_RSHIFT) shift_f <= 1'b0;
          if (code == SC_CTRL) ctrl_f <= 1'b0;
          break_f <= 1'b0;
          ext_f   <= 1'b0;
        end else if (ext_f) begin
          ext_f <= 1'b0;
          if (code == SC_ENTER) begin
            kbd_data  <= {1'b1, ASCII_CR};
            key_ready <= 1'b1;
          end
        end else if (code == SC_LSHIFT || code == SC_RSHIFT) begin
          shift_f <= 1'b1;
        end else if (code == SC_CTRL) begin
          ctrl_f <= 1'b1;
        end else if (code == SC_F1) begin
          clr_screen <= 1'b1;
        end else if (map_hit) begin
          // Written after the read clear so a coincident new character wins.
          kbd_data  <= {1'b1, char_out};
          key_ready <= 1'b1;
        end
      end
    end
  end

  assign bus.dout       = bus.address ? {key_ready, 7'b0} : kbd_data;
  assign bus.key_ready  = key_ready;
  assign bus.clr_screen = clr_screen;
  assign bus.frame_err  = rx_frame_err;
  assign bus.rx_state   = rx_state;

endmodule
